// File: rtl/mult_stream_ctrl.sv
// Valid/ready streaming controller for an external 10-stage shift-add multiplier.
// Holds operands for the multiplier, captures its product and queues {a,b,product} in a small FIFO.
module mult_stream_ctrl #(
  parameter int OP_W       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit CHECK_EN   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [OP_W-1:0]               op_a,
  input  logic [OP_W-1:0]               op_b,
  output logic                          mul_rst,
  output logic [OP_W-1:0]               mul_in1,
  output logic [OP_W-1:0]               mul_in2,
  input  logic [2*OP_W-1:0]             mul_out,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [OP_W-1:0]               res_a,
  output logic [OP_W-1:0]               res_b,
  output logic [2*OP_W-1:0]             res_prod,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          chk_err
);

  localparam int PW = 2 * OP_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] LAST_PHASE = 4'd9;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [3:0]        phase_q, phase_d;
  logic              mul_rst_q, mul_rst_d;
  logic [OP_W-1:0]   in1_q, in1_d;
  logic [OP_W-1:0]   in2_q, in2_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              chk_err_q, chk_err_d;

  logic [OP_W-1:0]   a_mem [FIFO_DEPTH];
  logic [OP_W-1:0]   b_mem [FIFO_DEPTH];
  logic [PW-1:0]     p_mem [FIFO_DEPTH];

  logic running, last_phase, accept, push, pop, fifo_full, head_valid;

  assign running    = (state_q == RUN);
  assign last_phase = running && (phase_q == LAST_PHASE);
  assign head_valid = (count_q != '0);
  assign fifo_full  = (int'(count_q) == FIFO_DEPTH);

  // Accept only when the result of this op is guaranteed a FIFO slot; pops are not credited.
  assign op_ready = rst_n && !flush && (!running || last_phase) &&
                    ((int'(count_q) + int'(running)) < FIFO_DEPTH);
  assign accept   = op_valid && op_ready;
  assign push     = last_phase && !flush;
  assign pop      = head_valid && res_ready && !flush;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    mul_rst_d = mul_rst_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    if (flush) begin
      state_d   = IDLE;
      phase_d   = '0;
      mul_rst_d = 1'b1;
    end else if (accept) begin
      state_d   = RUN;
      phase_d   = '0;
      mul_rst_d = 1'b0;
      in1_d     = op_a;
      in2_d     = op_b;
    end else if (last_phase) begin
      state_d   = IDLE;
      phase_d   = '0;
      mul_rst_d = 1'b1;
    end else if (running) begin
      phase_d   = phase_q + 4'd1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  generate
    if (CHECK_EN) begin : g_chk
      logic [PW-1:0] exp_prod;
      assign exp_prod = PW'(in1_q) * PW'(in2_q);
      always_comb chk_err_d = chk_err_q | (push && (mul_out != exp_prod));
    end else begin : g_nochk
      assign chk_err_d = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      mul_rst_q <= 1'b1;
      in1_q     <= '0;
      in2_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      chk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      mul_rst_q <= mul_rst_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      chk_err_q <= chk_err_d;
    end
  end

  // Payload storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_q] <= in1_q;
      b_mem[wr_ptr_q] <= in2_q;
      p_mem[wr_ptr_q] <= mul_out;
    end
  end

  assign mul_rst    = mul_rst_q;
  assign mul_in1    = in1_q;
  assign mul_in2    = in2_q;
  assign busy       = running;
  assign fifo_count = count_q;
  assign chk_err    = chk_err_q;
  assign res_valid  = head_valid;
  assign res_a      = head_valid ? a_mem[rd_ptr_q] : '0;
  assign res_b      = head_valid ? b_mem[rd_ptr_q] : '0;
  assign res_prod   = head_valid ? p_mem[rd_ptr_q] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_mult_stream_ctrl.sv
// Bench for mult_stream_ctrl: bench-side 10-stage multiplier, per-cycle model compare,
// and directed scenarios with hand-computed expectations.
module tb_mult_stream_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, op_valid, op_ready, mul_rst, res_valid, res_ready, busy, chk_err;
  logic [7:0]  op_a, op_b, mul_in1, mul_in2, res_a, res_b;
  logic [15:0] mul_out, res_prod, force_val;
  logic [2:0]  fifo_count;
  logic        force_en;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mult_stream_ctrl #(.OP_W(8), .FIFO_DEPTH(DEPTH), .CHECK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mul_rst(mul_rst), .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_a(res_a), .res_b(res_b),
    .res_prod(res_prod), .busy(busy), .fifo_count(fifo_count), .chk_err(chk_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: product only valid in stage 9, garbage elsewhere.
  logic [3:0] stg = 4'd0;
  always @(posedge clk) begin
    if (mul_rst) stg <= 4'd0;
    else         stg <= (stg == 4'd9) ? 4'd0 : stg + 4'd1;
  end
  assign mul_out = (stg == 4'd9) ? (force_en ? force_val : 16'(mul_in1) * 16'(mul_in2)) : 16'hBEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one op in flight with an age in cycles, plus a result queue.
  typedef struct packed {logic [7:0] a; logic [7:0] b; logic [15:0] p;} ent_t;
  ent_t        mq[$];
  bit          m_inflight = 1'b0;
  int          m_age = 0;
  logic [7:0]  m_a = 8'd0, m_b = 8'd0;
  bit          m_chk = 1'b0;
  bit          m_ready, m_acc;
  logic [15:0] m_p, m_true;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_inflight = 1'b0;
      m_age = 0;
      m_chk = 1'b0;
    end else begin
      m_ready = !flush && (!m_inflight || m_age == 10) &&
                (mq.size() + (m_inflight ? 1 : 0) < DEPTH);
      check("op_ready", 32'(op_ready), 32'(m_ready));
      check("busy", 32'(busy), 32'(m_inflight));
      check("mul_rst", 32'(mul_rst), 32'(!m_inflight));
      check("res_valid", 32'(res_valid), 32'(mq.size() != 0));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("chk_err", 32'(chk_err), 32'(m_chk));
      if (mq.size() != 0) begin
        check("res_a", 32'(res_a), 32'(mq[0].a));
        check("res_b", 32'(res_b), 32'(mq[0].b));
        check("res_prod", 32'(res_prod), 32'(mq[0].p));
      end
      if (m_inflight) begin
        check("mul_in1", 32'(mul_in1), 32'(m_a));
        check("mul_in2", 32'(mul_in2), 32'(m_b));
      end
      m_acc = op_valid && m_ready;
      if (flush) begin
        mq.delete();
        m_inflight = 1'b0;
        m_age = 0;
      end else begin
        if (mq.size() != 0 && res_ready) begin
          $display("pop  a=%0d b=%0d prod=%0d (cycle %0d)", mq[0].a, mq[0].b, mq[0].p, cyc);
          void'(mq.pop_front());
        end
        if (m_inflight && m_age == 10) begin
          m_true = 16'(m_a) * 16'(m_b);
          m_p = force_en ? force_val : m_true;
          mq.push_back('{a: m_a, b: m_b, p: m_p});
          if (m_p != m_true) m_chk = 1'b1;
          m_inflight = 1'b0;
        end
        if (m_inflight) m_age++;
        if (m_acc) begin
          m_inflight = 1'b1;
          m_age = 1;
          m_a = op_a;
          m_b = op_b;
        end
      end
    end
  end

  // Called at posedge+2; returns the cycle in which the pair was accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, output int t);
    op_a = a; op_b = b; op_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (op_ready) begin t = cyc; break; end
    end
    if (t < 0) check("send_timeout", 32'd0, 32'd1);
    else $display("send a=%0d b=%0d accepted cycle %0d", a, b, t);
    @(posedge clk); #2;
    op_valid = 1'b0;
  endtask

  task automatic wait_valid(output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin t = cyc; break; end
    end
    if (t < 0) check("res_timeout", 32'd0, 32'd1);
  endtask

  task automatic step_to(input int c);
    for (int i = 0; i < 200 && cyc < c; i++) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int t0, t1, t2, t3, tg, lowcnt;

  initial begin
    rst_n = 1'b0; flush = 1'b0; op_valid = 1'b1; op_a = 8'd1; op_b = 8'd1;
    res_ready = 1'b1; force_en = 1'b0; force_val = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_op_ready", 32'(op_ready), 32'd0);
    check("rst_mul_rst", 32'(mul_rst), 32'd1);
    check("rst_mul_in1", 32'(mul_in1), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_chk_err", 32'(chk_err), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1; op_valid = 1'b0;
    @(posedge clk); #2;

    // 3*5: latency 11, multiplier out of reset for exactly 10 cycles
    send(8'd3, 8'd5, t0);
    lowcnt = 0; tg = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!mul_rst) lowcnt++;
      if (res_valid) begin tg = cyc; break; end
    end
    check("lat_3x5", 32'(tg), 32'(t0 + 11));
    check("prod_3x5", 32'(res_prod), 32'd15);
    check("mul_rst_low_cycles", 32'(lowcnt), 32'd10);
    @(posedge clk); #2;

    // back-to-back 255*255 then 0*7
    send(8'd255, 8'd255, t1);
    send(8'd0, 8'd7, t2);
    check("b2b_accept_gap", 32'(t2 - t1), 32'd10);
    wait_valid(tg);
    check("lat_255x255", 32'(tg), 32'(t1 + 11));
    check("prod_255x255", 32'(res_prod), 32'd65025);
    wait_valid(tg);
    check("lat_0x7", 32'(tg), 32'(t2 + 11));
    check("prod_0x7", 32'(res_prod), 32'd0);
    @(posedge clk); #2;

    // stall downstream: 4 ops fill the FIFO, 5th must wait
    res_ready = 1'b0;
    send(8'd10, 8'd11, t0);
    send(8'd12, 8'd13, t0);
    send(8'd14, 8'd15, t0);
    send(8'd16, 8'd17, t0);
    op_a = 8'd18; op_b = 8'd19; op_valid = 1'b1;
    repeat (14) @(negedge clk);
    check("full_op_ready", 32'(op_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_head_a", 32'(res_a), 32'd10);
    @(posedge clk); #2;
    res_ready = 1'b1;
    send(8'd18, 8'd19, t0);
    send(8'd20, 8'd21, t0);
    repeat (40) @(posedge clk);
    #2;
    check("drain_chk_err", 32'(chk_err), 32'd0);
    check("drain_count", 32'(fifo_count), 32'd0);

    // simultaneous push and pop with two entries queued
    res_ready = 1'b0;
    send(8'd1, 8'd2, t0);
    send(8'd3, 8'd4, t0);
    send(8'd5, 8'd6, t3);
    step_to(t3 + 10);
    res_ready = 1'b1;
    @(posedge clk); #2;
    res_ready = 1'b0;
    @(negedge clk);
    check("pushpop_count", 32'(fifo_count), 32'd2);
    check("pushpop_head_a", 32'(res_a), 32'd3);
    check("pushpop_head_b", 32'(res_b), 32'd4);
    @(posedge clk); #2;
    res_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    // flush during phase 5 of 9*9 with one result already queued
    res_ready = 1'b0;
    send(8'd2, 8'd3, t0);
    send(8'd9, 8'd9, t1);
    step_to(t1 + 6);
    flush = 1'b1;
    @(negedge clk);
    check("pre_flush_count", 32'(fifo_count), 32'd1);
    check("flush_op_ready", 32'(op_ready), 32'd0);
    @(posedge clk); #2;
    flush = 1'b0;
    @(negedge clk);
    check("flush_mul_rst", 32'(mul_rst), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_count", 32'(fifo_count), 32'd0);
    repeat (15) @(negedge clk);
    check("flush_no_result", 32'(res_valid), 32'd0);
    @(posedge clk); #2;
    res_ready = 1'b1;

    // corrupted product: chk_err sets and sticks until rst_n
    force_en = 1'b1; force_val = 16'd14;
    send(8'd3, 8'd5, t0);
    wait_valid(tg);
    check("bad_prod", 32'(res_prod), 32'd14);
    check("bad_chk_err", 32'(chk_err), 32'd1);
    @(posedge clk); #2;
    force_en = 1'b0;
    send(8'd4, 8'd4, t0);
    wait_valid(tg);
    check("good_prod_after", 32'(res_prod), 32'd16);
    check("chk_err_sticky", 32'(chk_err), 32'd1);
    @(posedge clk); #2;
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    @(negedge clk);
    check("chk_err_after_flush", 32'(chk_err), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("chk_err_cleared", 32'(chk_err), 32'd0);
    check("rst2_mul_rst", 32'(mul_rst), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
